// File: rtl/tri_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tri_buf_pkg
//  Description : Shared types and helpers for the triangle list buffer:
//                payload width, reader FSM state encoding and a
//                saturating increment used by the optional statistics
//                counters (TRI_BUF_STATS_EN).
//  Revision    : 1.0  initial release
// ============================================================================
package tri_buf_pkg;

    // Width of one projected triangle; opaque to this block
    localparam int TRI_W = 160;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PSTART  = 3'd1,
        FETCH   = 3'd2,
        PRESENT = 3'd3,
        PEND    = 3'd4
    } rd_state_t;

    // 16-bit increment that sticks at all-ones
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tri_bank_ram.sv
`default_nettype none
// ============================================================================
//  Module      : tri_bank_ram
//  Description : Simple dual-port RAM holding both triangle banks
//                (2*DEPTH entries, address = {bank, idx}). The read data
//                passes through a RAM_LATENCY-deep output pipeline; the
//                first stage only loads when a read is issued, so the
//                output stays stable while no new read is requested.
//  Revision    : 1.0  initial release
// ============================================================================
module tri_bank_ram
    import tri_buf_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int RAM_LATENCY = 2,
    parameter int ADDR_W      = $clog2(2 * DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [TRI_W-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [TRI_W-1:0]  rdata
);

    logic [TRI_W-1:0] r_mem  [2*DEPTH];
    logic [TRI_W-1:0] r_pipe [RAM_LATENCY];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Read port: load on request, then shift through the output pipeline
    always_ff @(posedge clk) begin
        if (re) begin
            r_pipe[0] <= r_mem[raddr];
        end
        for (int i = 1; i < RAM_LATENCY; i++) begin
            r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign rdata = r_pipe[RAM_LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/triangle_list_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : triangle_list_buffer
//  Description : Double-buffered store for one frame of projected
//                triangles. Captures triangles until the projector reports
//                frame done, swaps banks at frame_start and replays the
//                stored list NUM_PASSES times (one per raster tile) over a
//                valid/ready interface.
//                Optional macro TRI_BUF_STATS_EN adds dropped_cnt and
//                stale_cnt saturating statistics outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module triangle_list_buffer
    import tri_buf_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int NUM_PASSES  = 4,
    parameter int RAM_LATENCY = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [TRI_W-1:0]              tri_in,
    input  logic                          tri_in_valid,
    input  logic                          frame_done_in,
    output logic                          accept_ready,
    input  logic                          frame_start,
    output logic [TRI_W-1:0]              tri_out,
    output logic                          tri_out_valid,
    input  logic                          tri_out_ready,
    output logic                          tri_out_last,
    output logic                          pass_start,
    output logic [$clog2(NUM_PASSES)-1:0] pass_idx,
    output logic                          pass_done,
    output logic                          busy,
    output logic                          overflow,
    output logic                          frame_overrun
`ifdef TRI_BUF_STATS_EN
    ,
    output logic [15:0]                   dropped_cnt,
    output logic [15:0]                   stale_cnt
`endif
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_PW = $clog2(NUM_PASSES);
    localparam int c_WW = $clog2(RAM_LATENCY + 1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    // ---------------- write side / swap state ----------------
    logic            r_wr_bank;
    logic [c_CW-1:0] r_wr_cnt;
    logic [c_CW-1:0] r_rd_cnt;
    logic            r_wr_closed;
    logic            r_done_d;
    logic            r_overflow;
    logic            r_fs;
    logic            r_overrun;

    // ---------------- reader state ----------------
    rd_state_t       r_state,  w_state_nxt;
    logic [c_CW-1:0] r_idx,    w_idx_nxt;
    logic [c_WW-1:0] r_wait,   w_wait_nxt;
    logic [c_PW-1:0] r_pass,   w_pass_nxt;
    logic            w_re;
    logic            w_last;
    logic [TRI_W-1:0] w_rdata;

    logic w_idle, w_done_rise, w_wr_try, w_wr_en, w_wr_ovf, w_swap, w_stale;

    assign w_idle      = (r_state == IDLE);
    assign w_done_rise = frame_done_in & ~r_done_d;
    assign w_wr_try    = tri_in_valid & ~r_wr_closed;
    assign w_wr_en     = w_wr_try & (r_wr_cnt != c_FULL);
    assign w_wr_ovf    = w_wr_try & (r_wr_cnt == c_FULL);
    // frame_start is registered once; the swap decision uses the delayed strobe
    assign w_swap      = r_fs & w_idle & r_wr_closed;
    assign w_stale     = r_fs & w_idle & ~r_wr_closed;
    assign w_last      = (r_idx == r_rd_cnt - c_CW'(1));

    tri_bank_ram #(
        .DEPTH       (DEPTH),
        .RAM_LATENCY (RAM_LATENCY),
        .ADDR_W      (c_AW + 1)
    ) u_ram (
        .clk   (clk),
        .we    (w_wr_en),
        .waddr ({r_wr_bank, r_wr_cnt[c_AW-1:0]}),
        .wdata (tri_in),
        .re    (w_re),
        .raddr ({~r_wr_bank, r_idx[c_AW-1:0]}),
        .rdata (w_rdata)
    );

    // Write counting, frame close on done rising edge, bank swap and overrun flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_bank   <= 1'b0;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_wr_closed <= 1'b0;
            r_done_d    <= 1'b0;
            r_overflow  <= 1'b0;
            r_fs        <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_done_d  <= frame_done_in;
            r_fs      <= frame_start;
            r_overrun <= r_fs & ~w_idle;
            if (w_swap) begin
                r_wr_bank   <= ~r_wr_bank;
                r_rd_cnt    <= r_wr_cnt;
                r_wr_cnt    <= '0;
                r_wr_closed <= 1'b0;
                r_overflow  <= 1'b0;
            end else begin
                if (w_wr_en) begin
                    r_wr_cnt <= r_wr_cnt + c_CW'(1);
                end
                if (w_wr_ovf) begin
                    r_overflow <= 1'b1;
                end
            end
            // A done edge coinciding with a swap closes the freshly opened bank
            if (w_done_rise) begin
                r_wr_closed <= 1'b1;
            end
        end
    end

    // Reader FSM state and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_wait  <= '0;
            r_pass  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_wait  <= w_wait_nxt;
            r_pass  <= w_pass_nxt;
        end
    end

    // Reader next-state and handshake outputs
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_wait_nxt    = r_wait;
        w_pass_nxt    = r_pass;
        w_re          = 1'b0;
        tri_out_valid = 1'b0;
        tri_out_last  = 1'b0;
        tri_out       = '0;
        pass_start    = 1'b0;
        pass_done     = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_fs) begin
                    w_state_nxt = PSTART;
                end
            end
            PSTART: begin
                pass_start  = 1'b1;
                w_idx_nxt   = '0;
                w_wait_nxt  = '0;
                w_state_nxt = (r_rd_cnt == '0) ? PEND : FETCH;
            end
            FETCH: begin
                w_re = (r_wait == '0);
                if (r_wait == c_WW'(RAM_LATENCY - 1)) begin
                    w_wait_nxt  = '0;
                    w_state_nxt = PRESENT;
                end else begin
                    w_wait_nxt = r_wait + c_WW'(1);
                end
            end
            PRESENT: begin
                tri_out_valid = 1'b1;
                tri_out_last  = w_last;
                tri_out       = w_rdata;
                if (tri_out_ready) begin
                    if (w_last) begin
                        w_state_nxt = PEND;
                    end else begin
                        w_idx_nxt   = r_idx + c_CW'(1);
                        w_state_nxt = FETCH;
                    end
                end
            end
            PEND: begin
                pass_done = 1'b1;
                if (r_pass != c_PW'(NUM_PASSES - 1)) begin
                    w_pass_nxt  = r_pass + c_PW'(1);
                    w_state_nxt = PSTART;
                end else begin
                    w_pass_nxt  = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign accept_ready  = ~r_wr_closed;
    assign pass_idx      = r_pass;
    assign busy          = ~w_idle;
    assign overflow      = r_overflow;
    assign frame_overrun = r_overrun;

`ifdef TRI_BUF_STATS_EN
    logic [15:0] r_dropped;
    logic [15:0] r_stale;

    // Saturating counts of dropped writes and stale-frame replays
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dropped <= '0;
            r_stale   <= '0;
        end else begin
            if (tri_in_valid & ~w_wr_en) begin
                r_dropped <= sat_inc(r_dropped);
            end
            if (w_stale) begin
                r_stale <= sat_inc(r_stale);
            end
        end
    end

    assign dropped_cnt = r_dropped;
    assign stale_cnt   = r_stale;
`endif

endmodule
`default_nettype wire
